// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipes -- shared types for the pipeline hazard controller.
//   ctrl_state_t  : redirect FSM state (RUN, REDIR_PEND)
//   hazard_ctrl_t : stall / bubble / flush bundle driven to the pipeline regs
//   HC_NONE       : the all-quiet bundle used for idle cycles and reset
// -----------------------------------------------------------------------------
package pipes;

    localparam int unsigned PC_W        = 64;
    localparam int unsigned STALL_CNT_W = 64;
    localparam int unsigned FLUSH_CNT_W = 32;

    typedef enum logic {
        RUN        = 1'b0,
        REDIR_PEND = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic bubble_d;
        logic bubble_e;
        logic bubble_m;
        logic bubble_w;
        logic flush_d;
    } hazard_ctrl_t;

    localparam hazard_ctrl_t HC_NONE = 9'b0_0000_0000;

endpackage

// File: rtl/hazard_ctrl_chk.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_chk -- protocol checker for hazard_ctrl.
//   clk, reset : as the controller
//   state      : controller FSM state
//   br_taken   : execute branch indication
// Execute must not resolve a taken branch while a redirect is pending.
// -----------------------------------------------------------------------------
module hazard_ctrl_chk
    import pipes::*;
(
    input logic        clk,
    input logic        reset,
    input ctrl_state_t state,
    input logic        br_taken
);

    no_branch_while_pending: assert property (
        @(posedge clk) disable iff (reset) !((state == REDIR_PEND) && br_taken)
    ) else $error("protocol: br_taken asserted while redirect pending");

endmodule

// File: rtl/hazard_ctrl_perf_cnt.sv
// -----------------------------------------------------------------------------
// perf_cnt -- free-running event counter, wraps at 2^WIDTH.
//   clk   : clock
//   clear : synchronous clear, wins over en
//   en    : count this cycle
//   count : registered count; the value seen in cycle N+1 includes cycle N
// -----------------------------------------------------------------------------
module perf_cnt #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            count_r <= {WIDTH{1'b0}};
        end else if (en) begin
            count_r <= count_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl -- pipeline stall / bubble / flush / redirect controller.
//   Inputs : clk, reset (sync, active-high), if_wait, lu_hazard, mdu_start,
//            mdu_done, mem_req, mem_ok, br_taken, br_target[63:0]
//   Outputs: stall_f/d/e/m, bubble_d/e/m/w, flush_d, redirect_valid,
//            redirect_pc[63:0], stall_cnt[63:0], flush_cnt[31:0]
// Priority per cycle: mem busy > mdu busy > branch/pending redirect >
// load-use > fetch wait. A taken branch while fetch is still waiting is
// parked in REDIR_PEND with its target latched, and the redirect is issued
// in the first cycle fetch is free again.
// -----------------------------------------------------------------------------
module hazard_ctrl
    import pipes::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        if_wait,
    input  logic        lu_hazard,
    input  logic        mdu_start,
    input  logic        mdu_done,
    input  logic        mem_req,
    input  logic        mem_ok,
    input  logic        br_taken,
    input  logic [63:0] br_target,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        stall_m,
    output logic        bubble_d,
    output logic        bubble_e,
    output logic        bubble_m,
    output logic        bubble_w,
    output logic        flush_d,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic [63:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    ctrl_state_t             state_r;
    ctrl_state_t             state_nxt_s;
    logic [PC_W-1:0]         pc_r;
    logic [PC_W-1:0]         pc_nxt_s;
    hazard_ctrl_t            ctl_s;
    logic                    redirect_valid_s;
    logic [PC_W-1:0]         redirect_pc_s;
    logic                    flush_inc_s;
    logic                    mem_busy_s;
    logic                    mdu_busy_s;
    logic [STALL_CNT_W-1:0]  stall_cnt_r;
    logic [FLUSH_CNT_W-1:0]  flush_cnt_r;

    assign mem_busy_s = mem_req & ~mem_ok;
    assign mdu_busy_s = mdu_start & ~mdu_done;

    // State and latched redirect target register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= RUN;
            pc_r    <= 64'h0;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
        end
    end

    // Next-state logic; a mem or mdu stall freezes the FSM and the latched pc.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        if (mem_busy_s || mdu_busy_s) begin
            state_nxt_s = state_r;
        end else begin
            case (state_r)
                RUN: begin
                    if (br_taken && if_wait) begin
                        state_nxt_s = REDIR_PEND;
                        pc_nxt_s    = br_target;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end
                REDIR_PEND: begin
                    // A br_taken here is a protocol error and is ignored.
                    if (!if_wait) begin
                        state_nxt_s = RUN;
                    end else begin
                        state_nxt_s = REDIR_PEND;
                    end
                end
                default: begin
                    state_nxt_s = RUN;
                end
            endcase
        end
    end

    // Output decode in priority order; everything is quiet while in reset.
    always_comb begin
        ctl_s            = HC_NONE;
        redirect_valid_s = 1'b0;
        redirect_pc_s    = 64'h0;
        flush_inc_s      = 1'b0;
        if (reset) begin
            ctl_s = HC_NONE;
        end else if (mem_busy_s) begin
            // Execute is held, so a branch there will be re-presented.
            ctl_s.stall_f  = 1'b1;
            ctl_s.stall_d  = 1'b1;
            ctl_s.stall_e  = 1'b1;
            ctl_s.stall_m  = 1'b1;
            ctl_s.bubble_w = 1'b1;
        end else if (mdu_busy_s) begin
            ctl_s.stall_f  = 1'b1;
            ctl_s.stall_d  = 1'b1;
            ctl_s.stall_e  = 1'b1;
            ctl_s.bubble_m = 1'b1;
        end else if (state_r == REDIR_PEND) begin
            if (if_wait) begin
                ctl_s.stall_f = 1'b1;
                ctl_s.flush_d = 1'b1;
            end else begin
                redirect_valid_s = 1'b1;
                redirect_pc_s    = pc_r;
            end
        end else if (br_taken) begin
            ctl_s.flush_d  = 1'b1;
            ctl_s.bubble_e = 1'b1;
            flush_inc_s    = 1'b1;
            if (!if_wait) begin
                redirect_valid_s = 1'b1;
                redirect_pc_s    = br_target;
            end else begin
                redirect_valid_s = 1'b0;
            end
        end else if (lu_hazard) begin
            ctl_s.stall_f  = 1'b1;
            ctl_s.stall_d  = 1'b1;
            ctl_s.bubble_e = 1'b1;
        end else if (if_wait) begin
            ctl_s.stall_f  = 1'b1;
            ctl_s.bubble_d = 1'b1;
        end else begin
            ctl_s = HC_NONE;
        end
    end

    perf_cnt #(.WIDTH(STALL_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .en    (ctl_s.stall_f),
        .count (stall_cnt_r)
    );

    perf_cnt #(.WIDTH(FLUSH_CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (reset),
        .en    (flush_inc_s),
        .count (flush_cnt_r)
    );

    assign stall_f        = ctl_s.stall_f;
    assign stall_d        = ctl_s.stall_d;
    assign stall_e        = ctl_s.stall_e;
    assign stall_m        = ctl_s.stall_m;
    assign bubble_d       = ctl_s.bubble_d;
    assign bubble_e       = ctl_s.bubble_e;
    assign bubble_m       = ctl_s.bubble_m;
    assign bubble_w       = ctl_s.bubble_w;
    assign flush_d        = ctl_s.flush_d;
    assign redirect_valid = redirect_valid_s;
    assign redirect_pc    = redirect_pc_s;
    // Counters read as zero during reset like every other output.
    assign stall_cnt      = reset ? 64'h0 : stall_cnt_r;
    assign flush_cnt      = reset ? 32'h0 : flush_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl -- directed-vector bench with a scoreboard queue.
// The driver applies one vector per cycle just after posedge and pushes the
// hand-written expected outputs; the monitor pops and compares at negedge.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;
    import pipes::*;

    logic        clk;
    logic        reset;
    logic        if_wait, lu_hazard, mdu_start, mdu_done, mem_req, mem_ok, br_taken;
    logic [63:0] br_target;
    logic        stall_f, stall_d, stall_e, stall_m;
    logic        bubble_d, bubble_e, bubble_m, bubble_w, flush_d;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] stall_cnt;
    logic [31:0] flush_cnt;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .if_wait(if_wait), .lu_hazard(lu_hazard),
        .mdu_start(mdu_start), .mdu_done(mdu_done), .mem_req(mem_req),
        .mem_ok(mem_ok), .br_taken(br_taken), .br_target(br_target),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .bubble_d(bubble_d), .bubble_e(bubble_e), .bubble_m(bubble_m),
        .bubble_w(bubble_w), .flush_d(flush_d), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl_chk u_chk (
        .clk(clk), .reset(reset), .state(dut.state_r), .br_taken(br_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control bundle bit order: {f,d,e,m, bd,be,bm,bw, fl}
    localparam logic [8:0] C_NONE = 9'b0000_0000_0;
    localparam logic [8:0] C_MEM  = 9'b1111_0001_0;
    localparam logic [8:0] C_MDU  = 9'b1110_0010_0;
    localparam logic [8:0] C_BR   = 9'b0000_0100_1;
    localparam logic [8:0] C_PEND = 9'b1000_0000_1;
    localparam logic [8:0] C_LU   = 9'b1100_0100_0;
    localparam logic [8:0] C_FW   = 9'b1000_1000_0;

    typedef struct {
        string       name;
        logic [7:0]  in_v;   // {reset,if_wait,lu,mdu_start,mdu_done,mem_req,mem_ok,br}
        logic [63:0] tgt;
        logic [8:0]  ctl;
        logic        rv;
        logic [63:0] pc;
    } vec_t;

    typedef struct {
        string       name;
        logic [8:0]  ctl;
        logic        rv;
        logic [63:0] pc;
        logic [63:0] scnt;
        logic [31:0] fcnt;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input string nm, input logic [7:0] in_v,
                                input logic [63:0] tgt, input logic [8:0] ctl,
                                input logic rv, input logic [63:0] pc);
        vec_t v;
        v.name = nm; v.in_v = in_v; v.tgt = tgt; v.ctl = ctl; v.rv = rv; v.pc = pc;
        return v;
    endfunction

    // Monitor: pop one expectation per cycle and compare away from posedge.
    exp_t        e;
    logic [8:0]  act_ctl;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act_ctl = {stall_f, stall_d, stall_e, stall_m,
                       bubble_d, bubble_e, bubble_m, bubble_w, flush_d};
            total++;
            if (act_ctl !== e.ctl) begin
                bad++;
                $display("FAIL %s ctl: got %b want %b", e.name, act_ctl, e.ctl);
            end
            total++;
            if (redirect_valid !== e.rv) begin
                bad++;
                $display("FAIL %s redirect_valid: got %b want %b", e.name, redirect_valid, e.rv);
            end
            if (e.rv) begin
                total++;
                if (redirect_pc !== e.pc) begin
                    bad++;
                    $display("FAIL %s redirect_pc: got %h want %h", e.name, redirect_pc, e.pc);
                end
            end
            total++;
            if (stall_cnt !== e.scnt) begin
                bad++;
                $display("FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt, e.scnt);
            end
            total++;
            if (flush_cnt !== e.fcnt) begin
                bad++;
                $display("FAIL %s flush_cnt: got %0d want %0d", e.name, flush_cnt, e.fcnt);
            end
        end
    end

    // Driver: apply vectors, push expectations, track expected counters.
    initial begin
        logic [63:0] scnt;
        logic [31:0] fcnt;
        exp_t        x;
        int          guard;
        scnt = 64'd0;
        fcnt = 32'd0;
        {reset, if_wait, lu_hazard, mdu_start, mdu_done, mem_req, mem_ok, br_taken} = 8'b1000_0000;
        br_target = 64'h0;

        vecs.push_back(mk("reset",        8'b1000_0000, 64'h0, C_NONE, 1'b0, 64'h0));
        vecs.push_back(mk("reset_busy",   8'b1001_0101, 64'h99, C_NONE, 1'b0, 64'h0));
        vecs.push_back(mk("idle0",        8'b0000_0000, 64'h0, C_NONE, 1'b0, 64'h0));
        vecs.push_back(mk("mem1_br",      8'b0000_0101, 64'h77, C_MEM, 1'b0, 64'h0));
        vecs.push_back(mk("mem2",         8'b0000_0100, 64'h0, C_MEM, 1'b0, 64'h0));
        vecs.push_back(mk("mem3",         8'b0000_0100, 64'h0, C_MEM, 1'b0, 64'h0));
        vecs.push_back(mk("mem_ok",       8'b0000_0110, 64'h0, C_NONE, 1'b0, 64'h0));
        vecs.push_back(mk("br_now",       8'b0000_0001, 64'h8000_0040, C_BR, 1'b1, 64'h8000_0040));
        vecs.push_back(mk("idle1",        8'b0000_0000, 64'h0, C_NONE, 1'b0, 64'h0));
        vecs.push_back(mk("lu",           8'b0010_0000, 64'h0, C_LU, 1'b0, 64'h0));
        vecs.push_back(mk("idle2",        8'b0000_0000, 64'h0, C_NONE, 1'b0, 64'h0));
        vecs.push_back(mk("fetch_wait",   8'b0100_0000, 64'h0, C_FW, 1'b0, 64'h0));
        vecs.push_back(mk("br_wait",      8'b0100_0001, 64'h1234_5678, C_BR, 1'b0, 64'h0));
        vecs.push_back(mk("pend1",        8'b0100_0000, 64'h0, C_PEND, 1'b0, 64'h0));
        vecs.push_back(mk("pend2",        8'b0100_0000, 64'h0, C_PEND, 1'b0, 64'h0));
        vecs.push_back(mk("pend_leave",   8'b0000_0000, 64'h0, C_NONE, 1'b1, 64'h1234_5678));
        vecs.push_back(mk("idle3",        8'b0000_0000, 64'h0, C_NONE, 1'b0, 64'h0));
        vecs.push_back(mk("br_wait2",     8'b0100_0001, 64'hDEAD_BEEF_0000_0100, C_BR, 1'b0, 64'h0));
        vecs.push_back(mk("pend_mem1",    8'b0100_0100, 64'h0, C_MEM, 1'b0, 64'h0));
        vecs.push_back(mk("pend_mem2",    8'b0000_0100, 64'h0, C_MEM, 1'b0, 64'h0));
        vecs.push_back(mk("pend_lu",      8'b0110_0000, 64'h0, C_PEND, 1'b0, 64'h0));
        vecs.push_back(mk("pend_leave2",  8'b0000_0000, 64'h0, C_NONE, 1'b1, 64'hDEAD_BEEF_0000_0100));
        vecs.push_back(mk("mdu_alone",    8'b0001_0000, 64'h0, C_MDU, 1'b0, 64'h0));
        vecs.push_back(mk("mdu_br1",      8'b0001_0001, 64'h4000, C_MDU, 1'b0, 64'h0));
        vecs.push_back(mk("mdu_br2",      8'b0001_0001, 64'h4000, C_MDU, 1'b0, 64'h0));
        vecs.push_back(mk("mdu_br3",      8'b0001_0001, 64'h4000, C_MDU, 1'b0, 64'h0));
        vecs.push_back(mk("mdu_br4",      8'b0001_0001, 64'h4000, C_MDU, 1'b0, 64'h0));
        vecs.push_back(mk("mdu_done_br",  8'b0001_1001, 64'h4000, C_BR, 1'b1, 64'h4000));
        vecs.push_back(mk("idle4",        8'b0000_0000, 64'h0, C_NONE, 1'b0, 64'h0));
        vecs.push_back(mk("mem_over_all", 8'b0111_0100, 64'h0, C_MEM, 1'b0, 64'h0));
        vecs.push_back(mk("mdu_over_mem", 8'b0001_0110, 64'h0, C_MDU, 1'b0, 64'h0));
        vecs.push_back(mk("br_wait3",     8'b0100_0001, 64'h55, C_BR, 1'b0, 64'h0));
        vecs.push_back(mk("pend3",        8'b0100_0000, 64'h0, C_PEND, 1'b0, 64'h0));
        vecs.push_back(mk("reset_pend",   8'b1100_0000, 64'h0, C_NONE, 1'b0, 64'h0));
        vecs.push_back(mk("after_reset",  8'b0000_0000, 64'h0, C_NONE, 1'b0, 64'h0));
        vecs.push_back(mk("run_fw",       8'b0100_0000, 64'h0, C_FW, 1'b0, 64'h0));
        vecs.push_back(mk("idle5",        8'b0000_0000, 64'h0, C_NONE, 1'b0, 64'h0));

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            {reset, if_wait, lu_hazard, mdu_start, mdu_done, mem_req, mem_ok, br_taken} = vecs[i].in_v;
            br_target = vecs[i].tgt;
            x.name = vecs[i].name;
            x.ctl  = vecs[i].ctl;
            x.rv   = vecs[i].rv;
            x.pc   = vecs[i].pc;
            x.scnt = vecs[i].in_v[7] ? 64'd0 : scnt;
            x.fcnt = vecs[i].in_v[7] ? 32'd0 : fcnt;
            exp_q.push_back(x);
            if (vecs[i].in_v[7]) begin
                scnt = 64'd0;
                fcnt = 32'd0;
            end else begin
                scnt = scnt + {63'd0, vecs[i].ctl[8]};
                fcnt = fcnt + {31'd0, vecs[i].ctl[0] & vecs[i].ctl[3]};
            end
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
